// File: rtl/uart_pkg.sv
// Shared UART definitions: word length, oversampling ratio and receiver FSM states.
package uart_pkg;

  localparam int DATALEN         = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_if.sv
// Receiver-to-host bundle: the receiver drives the master side, the APB wrapper reads the slave side.
interface uart_if import uart_pkg::*; ();

  logic [DATALEN-1:0] rx_data;
  logic               rx_busy;
  logic               rx_done;

  modport master (output rx_data, output rx_busy, output rx_done);
  modport slave  (input  rx_data, input  rx_busy, input  rx_done);

endinterface

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous input; flops reset to logic 1 (idle line level).
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVERSAMPLE x baud sampling; reports each correctly framed word with a one-clk rx_done.
module uart_rx import uart_pkg::*; #(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btick,
  input  logic   rx,
  uart_if.master urx
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATALEN > 1) ? $clog2(DATALEN) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATALEN - 1);

  logic rx_s;

  uart_rx_state_e     state_r,  state_nxt;
  logic [TICK_W-1:0]  tick_r,   tick_nxt;
  logic [BIT_W-1:0]   bit_r,    bit_nxt;
  logic [DATALEN-1:0] shift_r,  shift_nxt;
  logic [DATALEN-1:0] data_r,   data_nxt;
  logic               armed_r,  armed_nxt;
  logic               busy_r,   busy_nxt;
  logic               done_r,   done_nxt;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RX_IDLE;
      tick_r  <= TICK_W'(0);
      bit_r   <= BIT_W'(0);
      shift_r <= DATALEN'(0);
      data_r  <= DATALEN'(0);
      armed_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      tick_r  <= tick_nxt;
      bit_r   <= bit_nxt;
      shift_r <= shift_nxt;
      data_r  <= data_nxt;
      armed_r <= armed_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
    end
  end

  // Next-state logic; everything advances only on btick.
  always_comb begin
    state_nxt = state_r;
    tick_nxt  = tick_r;
    bit_nxt   = bit_r;
    shift_nxt = shift_r;
    data_nxt  = data_r;
    armed_nxt = armed_r;
    done_nxt  = 1'b0;

    if (btick) begin
      case (state_r)
        RX_IDLE: begin
          // After a framing error a held-low line (break) must be seen high before re-arming.
          if (rx_s) begin
            armed_nxt = 1'b1;
          end else if (armed_r) begin
            tick_nxt  = TICK_W'(0);
            state_nxt = RX_START;
          end else begin
            state_nxt = RX_IDLE;
          end
        end

        RX_START: begin
          if (tick_r == TICK_MID) begin
            if (!rx_s) begin
              tick_nxt  = TICK_W'(0);
              bit_nxt   = BIT_W'(0);
              state_nxt = RX_DATA;
            end else begin
              state_nxt = RX_IDLE;
            end
          end else begin
            tick_nxt = tick_r + TICK_W'(1);
          end
        end

        RX_DATA: begin
          tick_nxt = tick_r + TICK_W'(1);
          if (tick_r == TICK_LAST) begin
            shift_nxt = {rx_s, shift_r[DATALEN-1:1]};
            if (bit_r == BIT_LAST) begin
              state_nxt = RX_STOP;
            end else begin
              bit_nxt = bit_r + BIT_W'(1);
            end
          end else begin
            shift_nxt = shift_r;
          end
        end

        RX_STOP: begin
          tick_nxt = tick_r + TICK_W'(1);
          if (tick_r == TICK_LAST) begin
            state_nxt = RX_IDLE;
            if (rx_s) begin
              data_nxt = shift_r;
              done_nxt = 1'b1;
            end else begin
              armed_nxt = 1'b0;
            end
          end else begin
            state_nxt = RX_STOP;
          end
        end

        default: begin
          state_nxt = RX_IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end

    busy_nxt = (state_nxt != RX_IDLE);
  end

  assign urx.rx_data = data_r;
  assign urx.rx_busy = busy_r;
  assign urx.rx_done = done_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written multi-frame corner cases.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       fast;
    int         exp_done;
    logic [7:0] exp_data;
  } vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic btick = 1'b0;
  logic rx    = 1'b1;
  logic fast  = 1'b0;

  int tests = 0;
  int fails = 0;
  int bcnt  = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] data_q[$];
  int         cyc_q[$];

  uart_if bus ();

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .btick (btick),
    .rx    (rx),
    .urx   (bus)
  );

  always #5 clk = ~clk;

  // Cycle stamp.
  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick: every 4 clks, or every clk in fast mode.
  always @(negedge clk) begin
    bcnt  <= (bcnt == 3) ? 0 : bcnt + 1;
    btick <= fast || (bcnt == 3);
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      data_q.push_back(bus.rx_data);
      cyc_q.push_back(cyc);
    end
    if (bus.rx_busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bitlen();
    return fast ? 16 : 64;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(bitlen());
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  vec_t vecs[8];
  int   d0;
  int   b0;
  int   gap;

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, fast: 1'b0, exp_done: 1, exp_data: 8'h55};
    vecs[1] = '{data: 8'h00, stop: 1'b1, fast: 1'b0, exp_done: 1, exp_data: 8'h00};
    vecs[2] = '{data: 8'h80, stop: 1'b1, fast: 1'b0, exp_done: 1, exp_data: 8'h80};
    vecs[3] = '{data: 8'h81, stop: 1'b0, fast: 1'b0, exp_done: 0, exp_data: 8'h80};
    vecs[4] = '{data: 8'h01, stop: 1'b1, fast: 1'b0, exp_done: 1, exp_data: 8'h01};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, fast: 1'b1, exp_done: 1, exp_data: 8'hFF};
    vecs[6] = '{data: 8'h5A, stop: 1'b1, fast: 1'b1, exp_done: 1, exp_data: 8'h5A};
    vecs[7] = '{data: 8'h00, stop: 1'b0, fast: 1'b1, exp_done: 0, exp_data: 8'h5A};

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(3);
    check("reset_data", int'(bus.rx_data), 0);
    check("reset_busy", int'(bus.rx_busy), 0);
    check("reset_done", int'(bus.rx_done), 0);
    rst = 1'b0;
    wait_clks(128);

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      fast = vecs[i].fast;
      rx   = 1'b1;
      wait_clks(8);
      d0 = done_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      rx = 1'b1;
      wait_clks(2 * bitlen());
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_data", i), int'(bus.rx_data), int'(vecs[i].exp_data));
    end
    fast = 1'b0;
    rx   = 1'b1;
    wait_clks(128);

    // Single frame with busy timing
    check("sf_busy_idle", int'(bus.rx_busy), 0);
    d0 = done_cnt;
    rx = 1'b0;
    wait_clks(8);
    check("sf_busy_start", int'(bus.rx_busy), 1);
    wait_clks(56);
    for (int i = 0; i < 8; i++) send_bit(i[0] == 1'b0);
    send_bit(1'b1);
    wait_clks(64);
    check("sf_done", done_cnt - d0, 1);
    if (done_cnt - d0 >= 1) check("sf_data", int'(data_q[d0]), 8'h55);
    check("sf_busy_end", int'(bus.rx_busy), 0);

    // Back-to-back frames
    d0 = done_cnt;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    rx = 1'b1;
    wait_clks(128);
    check("b2b_done", done_cnt - d0, 2);
    if (done_cnt - d0 >= 2) begin
      check("b2b_data0", int'(data_q[d0]), 8'hA3);
      check("b2b_data1", int'(data_q[d0+1]), 8'h0F);
      gap = cyc_q[d0+1] - cyc_q[d0];
      check("b2b_gap", int'(gap >= 636 && gap <= 644), 1);
    end

    // Glitch: 12 clks low
    d0 = done_cnt;
    b0 = busy_cnt;
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(128);
    check("glitch_busy_pulse", int'(busy_cnt > b0), 1);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_data", int'(bus.rx_data), 8'h0F);
    check("glitch_busy_low", int'(bus.rx_busy), 0);
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    wait_clks(128);
    check("glitch_next_done", done_cnt - d0, 1);
    check("glitch_next_data", int'(bus.rx_data), 8'h3C);

    // Framing error followed by a break
    d0 = done_cnt;
    send_frame(8'h81, 1'b0);
    b0 = busy_cnt;
    rx = 1'b0;
    wait_clks(3 * 64);
    check("ferr_no_restart", busy_cnt - b0, 0);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_data_held", int'(bus.rx_data), 8'h3C);
    rx = 1'b1;
    wait_clks(128);
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    wait_clks(128);
    check("ferr_next_done", done_cnt - d0, 1);
    check("ferr_next_data", int'(bus.rx_data), 8'h7E);

    // Reset during data bit 4
    d0 = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b0;
    wait_clks(32);
    check("rst_busy_before", int'(bus.rx_busy), 1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    rx  = 1'b1;
    check("rst_busy", int'(bus.rx_busy), 0);
    check("rst_done", int'(bus.rx_done), 0);
    check("rst_data", int'(bus.rx_data), 0);
    wait_clks(256);
    check("rst_no_done", done_cnt - d0, 0);
    send_frame(8'hC6, 1'b1);
    rx = 1'b1;
    wait_clks(128);
    check("rst_next_done", done_cnt - d0, 1);
    check("rst_next_data", int'(bus.rx_data), 8'hC6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
